led_pattern_gen: RTL and testbench

Parametrised LED pattern sequencer for the board LED bank. It is the successor of the fixed 8-LED, 2-bit-select pattern block, generalised to `WIDTH` LEDs and given a runtime step-rate prescaler, a pause input, two added modes and a period-wrap strobe. It sits between the board-control registers or switches (`sel`, `div`, `en`) and the LED pins.

---
 rtl/led_pattern_gen.sv | 111 +++++++++++
 tb/tb_led_pattern_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: parametrised LED pattern sequencer.
//   Steps through one of several LED patterns at a programmable rate.
//   Every div+1 enabled cycles the next step of the selected pattern
//   is loaded into the LED register.
// Ports:
//   clk  - single clock
//   rst  - synchronous, active-high reset
//   sel  - pattern mode select (0..7)
//   div  - prescaler terminal count (step every div+1 enabled cycles)
//   en   - run enable; 0 freezes prescaler, phase and led
//   led  - registered LED drive (inverted when LED_INV=1)
//   wrap - one-cycle strobe while the last step of a period is first shown
module led_pattern_gen #(
    parameter int WIDTH   = 8,
    parameter int DIV_W   = 24,
    parameter bit LED_INV = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       sel,
    input  logic [DIV_W-1:0] div,
    input  logic             en,
    output logic [WIDTH-1:0] led,
    output logic             wrap
);
    localparam int H = WIDTH / 2;
    // WIDTH bits cover the binary-count mode, and 2*WIDTH-1 < 2^WIDTH
    // whenever WIDTH >= 4, so the other modes fit as well.
    localparam int PH_W = WIDTH;

    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALT  = {H{2'b01}};

    logic [DIV_W-1:0] cnt;
    logic [PH_W-1:0]  ph;
    logic [PH_W-1:0]  last;
    logic [PH_W-1:0]  kk;
    logic [2:0]       mode_q;
    logic [WIDTH-1:0] led_q;
    logic [WIDTH-1:0] pat;
    logic [WIDTH-1:0] lo_m;
    logic [WIDTH-1:0] hi_m;

    // Pattern for the current phase, before output inversion.
    always_comb begin
        pat  = '0;
        kk   = (ph < PH_W'(H)) ? ph : ph - PH_W'(H);
        // Masks of the kk+1 lowest / kk+1 highest bits (converge/clear).
        lo_m = ONES >> (PH_W'(WIDTH - 1) - kk);
        hi_m = ~(ONES >> (kk + PH_W'(1)));
        case (mode_q)
            3'd0: pat = ph[0] ? ~ALT : ALT;
            3'd1: begin
                if (ph < PH_W'(WIDTH)) pat = ONES >> (PH_W'(WIDTH - 1) - ph);
                else                   pat = ONES << (ph - PH_W'(WIDTH - 1));
            end
            3'd2: pat = (ph < PH_W'(H)) ? (lo_m | hi_m) : ~(lo_m | hi_m);
            3'd3: begin
                if (ph < PH_W'(WIDTH)) pat = ONE << ph;
                else                   pat = ONE << (PH_W'(2 * WIDTH - 2) - ph);
            end
            3'd4:    pat = ph;
            default: pat = '0;
        endcase
    end

    // Index of the final step (P-1) of the current mode.
    always_comb begin
        case (mode_q)
            3'd0:    last = PH_W'(1);
            3'd1:    last = PH_W'(2 * WIDTH - 1);
            3'd2:    last = PH_W'(WIDTH - 1);
            3'd3:    last = PH_W'(2 * WIDTH - 3);
            3'd4:    last = '1;
            default: last = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            ph     <= '0;
            mode_q <= '0;
            led_q  <= '0;
            wrap   <= 1'b0;
        end else if (sel != mode_q) begin
            // Relatch wins over a tick and ignores en; led is left as is.
            mode_q <= sel;
            ph     <= '0;
            cnt    <= '0;
            wrap   <= 1'b0;
        end else if (en) begin
            if (cnt == div) begin
                cnt   <= '0;
                led_q <= pat;
                wrap  <= (ph == last);
                ph    <= (ph == last) ? '0 : ph + PH_W'(1);
            end else begin
                // Free-running wrap when div is lowered below cnt.
                cnt  <= cnt + DIV_W'(1);
                wrap <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

    assign led = LED_INV ? ~led_q : led_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: a WIDTH=8 instance and a WIDTH=4 inverted
// instance share one stimulus stream (directed scenarios, then random)
// and are compared every cycle against a bit-rule reference model.
module tb_led_pattern_gen;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sel;
    logic       en;
    logic [3:0] divv;
    logic [4:0] div8;
    logic [3:0] div4;
    logic [7:0] led8;
    logic [3:0] led4;
    logic       wrap8, wrap4;

    int n_vec = 0;
    int n_err = 0;

    // model state: index 0 = 8-LED instance, 1 = 4-LED inverted instance
    int m_cnt[2], m_ph[2], m_mode[2], m_led[2];
    bit m_wrap[2];
    int m_w[2]   = '{8, 4};
    int m_cmax[2] = '{32, 16};

    assign div8 = {1'b0, divv};
    assign div4 = divv;

    always #5 clk = ~clk;

    led_pattern_gen #(.WIDTH(8), .DIV_W(5), .LED_INV(1'b0)) dut8 (
        .clk(clk), .rst(rst), .sel(sel), .div(div8), .en(en),
        .led(led8), .wrap(wrap8));

    led_pattern_gen #(.WIDTH(4), .DIV_W(4), .LED_INV(1'b1)) dut4 (
        .clk(clk), .rst(rst), .sel(sel), .div(div4), .en(en),
        .led(led4), .wrap(wrap4));

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int period(input int w, input int m);
        case (m)
            0:       return 2;
            1:       return 2 * w;
            2:       return w;
            3:       return 2 * w - 2;
            4:       return 1 << w;
            default: return 1;
        endcase
    endfunction

    // Step k of mode m, built bit by bit from the pattern definitions.
    function automatic int pattern(input int w, input int m, input int k);
        int r = 0;
        int h = w / 2;
        bit b;
        for (int i = 0; i < w; i++) begin
            b = 1'b0;
            case (m)
                0: b = ((i % 2) == (k % 2));
                1: b = (k < w) ? (i <= k) : (i > k - w);
                2: b = (k < h) ? (i <= k || i >= w - 1 - k)
                               : !(i <= k - h || i >= w - 1 - (k - h));
                3: b = (k < w) ? (i == k) : (i == 2 * w - 2 - k);
                4: b = ((k >> i) & 1) == 1;
                default: b = 1'b0;
            endcase
            if (b) r |= (1 << i);
        end
        return r;
    endfunction

    task automatic model_step();
        for (int x = 0; x < 2; x++) begin
            if (rst) begin
                m_cnt[x] = 0; m_ph[x] = 0; m_mode[x] = 0; m_led[x] = 0; m_wrap[x] = 0;
            end else if (int'(sel) != m_mode[x]) begin
                m_mode[x] = int'(sel); m_ph[x] = 0; m_cnt[x] = 0; m_wrap[x] = 0;
            end else if (en) begin
                if (m_cnt[x] == int'(divv)) begin
                    m_cnt[x]  = 0;
                    m_led[x]  = pattern(m_w[x], m_mode[x], m_ph[x]);
                    m_wrap[x] = (m_ph[x] == period(m_w[x], m_mode[x]) - 1);
                    m_ph[x]   = (m_ph[x] + 1) % period(m_w[x], m_mode[x]);
                end else begin
                    m_cnt[x]  = (m_cnt[x] + 1) % m_cmax[x];
                    m_wrap[x] = 0;
                end
            end else begin
                m_wrap[x] = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("led8", int'(led8), m_led[0]);
        chk("wrap8", int'(wrap8), int'(m_wrap[0]));
        chk("led4", int'(led4), (~m_led[1]) & 'hF);
        chk("wrap4", int'(wrap4), int'(m_wrap[1]));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b1; sel = 3'd0; en = 1'b1; divv = 4'd0;
        for (int x = 0; x < 2; x++) begin
            m_cnt[x] = 0; m_ph[x] = 0; m_mode[x] = 0; m_led[x] = 0; m_wrap[x] = 0;
        end
        // reset, mode 0 at full rate
        run(3);
        chk("rst_led8", int'(led8), 'h00);
        chk("rst_led4_inv", int'(led4), 'hF);
        rst = 1'b0;
        cycle();
        chk("m0_first", int'(led8), 'h55);
        cycle();
        chk("m0_second", int'(led8), 'hAA);
        chk("m0_wrap", int'(wrap8), 1);
        run(6);
        // fill/drain at div=2
        sel = 3'd1; divv = 4'd2;
        run(60);
        // converge/clear, then bounce mid-sequence
        sel = 3'd2; divv = 4'd0;
        run(13);
        sel = 3'd3;
        run(1);
        chk("m3_frozen", int'(led8), m_led[0]);
        run(30);
        // binary count with pause, then reset mid-count
        sel = 3'd4;
        run(20);
        en = 1'b0;
        run(10);
        en = 1'b1;
        run(25);
        rst = 1'b1;
        run(1);
        chk("rst_mid", int'(led8), 'h00);
        rst = 1'b0;
        run(40);
        // runtime div change from 5 to 1 while cnt is 3
        divv = 4'd5;
        begin
            int guard = 0;
            while (m_cnt[0] != 3 && guard < 100) begin
                cycle();
                guard++;
            end
            chk("div_wait_bound", int'(guard < 100), 1);
        end
        divv = 4'd1;
        run(80);
        // random phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) rst = 1'b1; else rst = 1'b0;
            if ($urandom_range(49) == 0) sel = 3'($urandom_range(7));
            en = ($urandom_range(7) != 0);
            if ($urandom_range(39) == 0) divv = 4'($urandom_range(3));
            cycle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
